uart_alu_frame_interface: RTL and testbench

- Second-generation bridge between the UART byte receiver/transmitter and the ALU.
- Assembles multi-byte operands A and B and an opcode byte from the RX byte stream, then issues them to the ALU with a one-cycle valid pulse.
- Captures the ALU result and serialises it back to the UART TX as NB_DATA/NB_BYTE bytes, LSB first, under a valid/ready handshake.
- Adds an inter-byte timeout and frame-error reporting.

---
 rtl/uart_alu_frame_interface_if.sv | 39 +++
 rtl/uart_alu_frame_interface.sv | 210 +++++++++++++++++++++
 tb/tb_uart_alu_frame_interface.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_alu_frame_interface_if.sv
// Byte-stream, ALU and transmitter signals of the UART/ALU frame bridge.
// slave = the bridge, master = whatever drives its inputs.
interface uart_alu_frame_interface_if #(
  parameter int NB_BYTE   = 8,
  parameter int NB_DATA   = 16,
  parameter int NB_OPCODE = 6
);
  logic [NB_BYTE-1:0]   i_rx_byte;
  logic                 i_rx_valid;
  logic [NB_DATA-1:0]   o_operand_a;
  logic [NB_DATA-1:0]   o_operand_b;
  logic [NB_OPCODE-1:0] o_opcode;
  logic                 o_alu_valid;
  logic [NB_DATA-1:0]   i_alu_result;
  logic                 i_alu_result_valid;
  logic [NB_BYTE-1:0]   o_tx_byte;
  logic                 o_tx_valid;
  logic                 i_tx_ready;
  logic                 o_busy;
  logic                 o_frame_error;

  modport slave (
    input  i_rx_byte, i_rx_valid,
    input  i_alu_result, i_alu_result_valid,
    input  i_tx_ready,
    output o_operand_a, o_operand_b, o_opcode,
    output o_alu_valid, o_tx_byte, o_tx_valid,
    output o_busy, o_frame_error
  );

  modport master (
    output i_rx_byte, i_rx_valid,
    output i_alu_result, i_alu_result_valid,
    output i_tx_ready,
    input  o_operand_a, o_operand_b, o_opcode,
    input  o_alu_valid, o_tx_byte, o_tx_valid,
    input  o_busy, o_frame_error
  );
endinterface

// File: rtl/uart_alu_frame_interface.sv
// UART <-> ALU frame bridge: A, B, opcode in; result bytes out, LSB first.
// Optional checksum byte on RX and TX with `define UART_ALU_CHECKSUM_EN.
module uart_alu_frame_interface #(
  parameter int NB_BYTE        = 8,
  parameter int NB_DATA        = 16,
  parameter int NB_OPCODE      = 6,
  parameter int NB_TIMEOUT     = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic i_clock,
  input logic i_reset,
  uart_alu_frame_interface_if.slave bus
);

  localparam int N_BYTES = NB_DATA / NB_BYTE;
`ifdef UART_ALU_CHECKSUM_EN
  localparam int N_TX = N_BYTES + 1;
`else
  localparam int N_TX = N_BYTES;
`endif
  localparam int NB_CNT = $clog2(N_TX + 1);
  localparam logic [NB_CNT-1:0] LAST_RX = NB_CNT'(N_BYTES - 1);
  localparam logic [NB_CNT-1:0] LAST_TX = NB_CNT'(N_TX - 1);
  localparam logic [NB_TIMEOUT-1:0] TMO_LAST =
    NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    RX_A,
    RX_B,
    RX_OP,
`ifdef UART_ALU_CHECKSUM_EN
    RX_CHK,
`endif
    ISSUE,
    WAIT_ALU,
    TX_RESULT
  } state_t;

  state_t               state;
  logic [NB_CNT-1:0]    count;
  logic [NB_TIMEOUT-1:0] timer;
  logic [NB_DATA-1:0]   a_asm;
  logic [NB_DATA-1:0]   b_asm;
  logic [NB_DATA-1:0]   result;
  logic [NB_DATA-1:0]   operand_a;
  logic [NB_DATA-1:0]   operand_b;
  logic [NB_OPCODE-1:0] opcode;
  logic                 alu_valid;
  logic                 frame_error;
  logic [NB_BYTE-1:0]   tx_byte;
  logic                 rx_phase;
  logic                 timing;
`ifdef UART_ALU_CHECKSUM_EN
  logic [NB_BYTE-1:0]   chk;
  logic [NB_OPCODE-1:0] op_asm;
  logic [NB_BYTE-1:0]   res_chk;
`endif

  always_comb begin
    rx_phase = (state == RX_A) || (state == RX_B) ||
`ifdef UART_ALU_CHECKSUM_EN
               (state == RX_CHK) ||
`endif
               (state == RX_OP);
  end

  // An idle RX_A with nothing assembled is not a partial frame.
  assign timing = rx_phase && !(state == RX_A && count == '0);

`ifdef UART_ALU_CHECKSUM_EN
  always_comb begin
    res_chk = '0;
    for (int i = 0; i < N_BYTES; i++)
      res_chk = res_chk ^ result[i*NB_BYTE +: NB_BYTE];
  end
`endif

  always_comb begin
    tx_byte = '0;
    if (state == TX_RESULT) begin
      if (count <= LAST_RX)
        tx_byte = result[int'(count)*NB_BYTE +: NB_BYTE];
`ifdef UART_ALU_CHECKSUM_EN
      else
        tx_byte = res_chk;
`endif
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state       <= RX_A;
      count       <= '0;
      timer       <= '0;
      a_asm       <= '0;
      b_asm       <= '0;
      result      <= '0;
      operand_a   <= '0;
      operand_b   <= '0;
      opcode      <= '0;
      alu_valid   <= 1'b0;
      frame_error <= 1'b0;
`ifdef UART_ALU_CHECKSUM_EN
      chk         <= '0;
      op_asm      <= '0;
`endif
    end else begin
      alu_valid   <= 1'b0;
      frame_error <= 1'b0;
      unique case (state)
        RX_A: if (bus.i_rx_valid) begin
          a_asm[int'(count)*NB_BYTE +: NB_BYTE] <= bus.i_rx_byte;
`ifdef UART_ALU_CHECKSUM_EN
          chk <= chk ^ bus.i_rx_byte;
`endif
          if (count == LAST_RX) begin
            count <= '0;
            state <= RX_B;
          end else begin
            count <= count + 1'b1;
          end
        end
        RX_B: if (bus.i_rx_valid) begin
          b_asm[int'(count)*NB_BYTE +: NB_BYTE] <= bus.i_rx_byte;
`ifdef UART_ALU_CHECKSUM_EN
          chk <= chk ^ bus.i_rx_byte;
`endif
          if (count == LAST_RX) begin
            count <= '0;
            state <= RX_OP;
          end else begin
            count <= count + 1'b1;
          end
        end
        RX_OP: if (bus.i_rx_valid) begin
`ifdef UART_ALU_CHECKSUM_EN
          chk    <= chk ^ bus.i_rx_byte;
          op_asm <= bus.i_rx_byte[NB_OPCODE-1:0];
          state  <= RX_CHK;
`else
          operand_a <= a_asm;
          operand_b <= b_asm;
          opcode    <= bus.i_rx_byte[NB_OPCODE-1:0];
          alu_valid <= 1'b1;
          state     <= ISSUE;
`endif
        end
`ifdef UART_ALU_CHECKSUM_EN
        RX_CHK: if (bus.i_rx_valid) begin
          chk <= '0;
          if (bus.i_rx_byte == chk) begin
            operand_a <= a_asm;
            operand_b <= b_asm;
            opcode    <= op_asm;
            alu_valid <= 1'b1;
            state     <= ISSUE;
          end else begin
            frame_error <= 1'b1;
            state       <= RX_A;
          end
        end
`endif
        ISSUE: state <= WAIT_ALU;
        WAIT_ALU: if (bus.i_alu_result_valid) begin
          result <= bus.i_alu_result;
          count  <= '0;
          state  <= TX_RESULT;
        end
        TX_RESULT: if (bus.i_tx_ready) begin
          if (count == LAST_TX) begin
            count <= '0;
            state <= RX_A;
`ifdef UART_ALU_CHECKSUM_EN
            chk   <= '0;
`endif
          end else begin
            count <= count + 1'b1;
          end
        end
        default: state <= RX_A;
      endcase

      if (bus.i_rx_valid || !timing) timer <= '0;
      else timer <= timer + 1'b1;

      // A byte arriving on the expiry cycle keeps the frame alive.
      if (timing && !bus.i_rx_valid && timer == TMO_LAST) begin
        frame_error <= 1'b1;
        state       <= RX_A;
        count       <= '0;
        timer       <= '0;
`ifdef UART_ALU_CHECKSUM_EN
        chk         <= '0;
`endif
      end

      if (bus.i_rx_valid && !rx_phase) frame_error <= 1'b1;
    end
  end

  assign bus.o_operand_a   = operand_a;
  assign bus.o_operand_b   = operand_b;
  assign bus.o_opcode      = opcode;
  assign bus.o_alu_valid   = alu_valid;
  assign bus.o_tx_byte     = tx_byte;
  assign bus.o_tx_valid    = (state == TX_RESULT);
  assign bus.o_busy        = !(state == RX_A && count == '0);
  assign bus.o_frame_error = frame_error;

endmodule

// File: tb/tb_uart_alu_frame_interface.sv
// Directed bench for uart_alu_frame_interface (16-bit operands, short timeout).
// Honours UART_ALU_CHECKSUM_EN when defined.
module tb_uart_alu_frame_interface;

  localparam int TMO = 20;
`ifdef UART_ALU_CHECKSUM_EN
  localparam int N_TX = 3;
`else
  localparam int N_TX = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_alu_frame_interface_if #(
    .NB_BYTE(8), .NB_DATA(16), .NB_OPCODE(6)
  ) bus ();

  uart_alu_frame_interface #(
    .NB_BYTE(8), .NB_DATA(16), .NB_OPCODE(6),
    .NB_TIMEOUT(16), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .bus(bus.slave)
  );

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [7:0]  a0, a1, b0, b1, opb;
    logic [15:0] a, b;
    logic [5:0]  op;
    logic [15:0] res;
  } vec_t;

  vec_t tbl[4];

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Called at a negedge; strobe is sampled on the following posedge.
  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_byte  = b;
    bus.i_rx_valid = 1'b1;
    @(negedge clk);
    bus.i_rx_valid = 1'b0;
    bus.i_rx_byte  = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] a0, a1, b0, b1, opb);
    send_byte(a0);
    send_byte(a1);
    send_byte(b0);
    send_byte(b1);
    send_byte(opb);
`ifdef UART_ALU_CHECKSUM_EN
    send_byte(a0 ^ a1 ^ b0 ^ b1 ^ opb);
`endif
  endtask

  task automatic check_issue(input string tag, input logic [15:0] a,
                             input logic [15:0] b, input logic [5:0] op);
    check({tag, "_alu_pulse"}, bus.o_alu_valid, 1);
    check({tag, "_op_a"}, bus.o_operand_a, a);
    check({tag, "_op_b"}, bus.o_operand_b, b);
    check({tag, "_opcode"}, bus.o_opcode, op);
    @(negedge clk);
    check({tag, "_alu_pulse_end"}, bus.o_alu_valid, 0);
  endtask

  task automatic collect_tx(input logic [15:0] res, input string tag);
    logic [7:0] exp_b[3];
    int n;
    n = 0;
    exp_b[0] = res[7:0];
    exp_b[1] = res[15:8];
    exp_b[2] = res[7:0] ^ res[15:8];
    bus.i_tx_ready = 1'b1;
    for (int c = 0; c < 16 && n < N_TX; c++) begin
      if (bus.o_tx_valid) begin
        check({tag, "_tx_byte"}, bus.o_tx_byte, exp_b[n]);
        n++;
      end
      @(negedge clk);
    end
    check({tag, "_tx_count"}, n, N_TX);
    check({tag, "_tx_drop"}, bus.o_tx_valid, 0);
    check({tag, "_idle"}, bus.o_busy, 0);
  endtask

  task automatic give_result(input logic [15:0] res);
    bus.i_alu_result       = res;
    bus.i_alu_result_valid = 1'b1;
    @(negedge clk);
    bus.i_alu_result_valid = 1'b0;
  endtask

  initial begin
    int errs;
    int idle;
    int bad;
    bus.i_rx_byte          = '0;
    bus.i_rx_valid         = 1'b0;
    bus.i_alu_result       = '0;
    bus.i_alu_result_valid = 1'b0;
    bus.i_tx_ready         = 1'b1;

    tbl[0] = '{8'h34, 8'h12, 8'h78, 8'h56, 8'h20,
               16'h1234, 16'h5678, 6'h20, 16'h68AC};
    tbl[1] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF,
               16'h00FF, 16'hFF00, 6'h3F, 16'hFFFF};
    tbl[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
               16'h0000, 16'h0000, 6'h00, 16'h0000};
    tbl[3] = '{8'hCD, 8'hAB, 8'h01, 8'h00, 8'h41,
               16'hABCD, 16'h0001, 6'h01, 16'h1357};

    repeat (2) @(negedge clk);
    check("rst_op_a", bus.o_operand_a, 0);
    check("rst_op_b", bus.o_operand_b, 0);
    check("rst_opcode", bus.o_opcode, 0);
    check("rst_alu_valid", bus.o_alu_valid, 0);
    check("rst_tx_valid", bus.o_tx_valid, 0);
    check("rst_tx_byte", bus.o_tx_byte, 0);
    check("rst_busy", bus.o_busy, 0);
    check("rst_frame_error", bus.o_frame_error, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      send_frame(tbl[i].a0, tbl[i].a1, tbl[i].b0, tbl[i].b1, tbl[i].opb);
      check_issue($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].op);
      give_result(tbl[i].res);
      collect_tx(tbl[i].res, $sformatf("vec%0d", i));
    end

    // Timeout after a lone byte
    send_byte(8'h11);
    check("tmo_busy", bus.o_busy, 1);
    idle = -1;
    for (int i = 0; i < 3 * TMO; i++) begin
      if (bus.o_frame_error) begin
        idle = i;
        break;
      end
      @(negedge clk);
    end
    check("tmo_cycles", idle, TMO);
    check("tmo_busy_clear", bus.o_busy, 0);
    check("tmo_hold_op_a", bus.o_operand_a, tbl[3].a);
    @(negedge clk);
    check("tmo_pulse_end", bus.o_frame_error, 0);
    send_frame(8'h66, 8'h55, 8'h88, 8'h77, 8'h03);
    check_issue("tmo_next", 16'h5566, 16'h7788, 6'h03);
    give_result(16'hBEEF);
    collect_tx(16'hBEEF, "tmo_next");

    // Byte on the expiry cycle wins
    errs = 0;
    send_byte(8'h22);
    repeat (TMO - 1) begin
      @(negedge clk);
      if (bus.o_frame_error) errs++;
    end
    send_byte(8'h33);
    if (bus.o_frame_error) errs++;
    send_byte(8'h02);
    send_byte(8'h00);
`ifdef UART_ALU_CHECKSUM_EN
    send_byte(8'h05);
    send_byte(8'h22 ^ 8'h33 ^ 8'h02 ^ 8'h00 ^ 8'h05);
`else
    send_byte(8'h05);
`endif
    check("race_no_error", errs, 0);
    check_issue("race", 16'h3322, 16'h0002, 6'h05);
    give_result(16'h0102);
    collect_tx(16'h0102, "race");

    // Back-pressure
    send_frame(8'h34, 8'h12, 8'h78, 8'h56, 8'h20);
    check_issue("bp", 16'h1234, 16'h5678, 6'h20);
    bus.i_tx_ready = 1'b0;
    give_result(16'h68AC);
    bad = 0;
    repeat (10) begin
      if (!bus.o_tx_valid || bus.o_tx_byte !== 8'hAC) bad++;
      @(negedge clk);
    end
    check("bp_stable", bad, 0);
    check("bp_byte", bus.o_tx_byte, 8'hAC);
    collect_tx(16'h68AC, "bp");

    // Overrun while waiting for the ALU
    send_frame(8'h0D, 8'hF0, 8'h0B, 8'hA0, 8'h07);
    check_issue("ovr", 16'hF00D, 16'hA00B, 6'h07);
    send_byte(8'hFF);
    check("ovr_error", bus.o_frame_error, 1);
    @(negedge clk);
    check("ovr_error_end", bus.o_frame_error, 0);
    give_result(16'h1111);
    collect_tx(16'h1111, "ovr");
    send_frame(8'h02, 8'h01, 8'h04, 8'h03, 8'h09);
    check_issue("ovr_next", 16'h0102, 16'h0304, 6'h09);
    give_result(16'h2222);
    collect_tx(16'h2222, "ovr_next");

    // Reset mid-frame
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_op_a", bus.o_operand_a, 0);
    check("mrst_op_b", bus.o_operand_b, 0);
    check("mrst_opcode", bus.o_opcode, 0);
    check("mrst_busy", bus.o_busy, 0);
    rst = 1'b0;
    @(negedge clk);
    send_frame(8'h34, 8'h12, 8'h78, 8'h56, 8'h20);
    check_issue("mrst_next", 16'h1234, 16'h5678, 6'h20);
    give_result(16'h68AC);
    collect_tx(16'h68AC, "mrst_next");

`ifdef UART_ALU_CHECKSUM_EN
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h03);
    check_issue("chk_ok", 16'h0001, 16'h0002, 6'h00);
    give_result(16'h0003);
    collect_tx(16'h0003, "chk_ok");
    send_frame(8'h34, 8'h12, 8'h78, 8'h56, 8'h20);
    check_issue("chk_prev", 16'h1234, 16'h5678, 6'h20);
    give_result(16'h0000);
    collect_tx(16'h0000, "chk_prev");
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h04);
    check("chk_bad_error", bus.o_frame_error, 1);
    check("chk_bad_no_issue", bus.o_alu_valid, 0);
    check("chk_bad_op_a", bus.o_operand_a, 16'h1234);
    check("chk_bad_busy", bus.o_busy, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
